reg_dump_reader: RTL and testbench
==================================

Name: reg_dump_reader

Overview:
- Debug-side reader for the CPU register file.
- On a start pulse it walks register addresses 0..NUM_REGS-1 through one register-file read port. Each word is snapshotted and streamed out as little-endian bytes over a valid/ready byte interface, e.g. to a UART transmitter.
- It replaces simulation-only register printing with a synthesizable dump path.

Parameters:
- NUM_REGS, 32, number of registers dumped, addresses 0..NUM_REGS-1.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- DATA_W, 32, register width; fixed at 32, giving 4 bytes per word.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  dump request; sampled only in IDLE.
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- done  output  1  one-cycle pulse after the last byte is accepted.
- rd_addr  output  ADDR_W  address driven to the register-file read port.
- rd_data  input  DATA_W  combinational read data for rd_addr, same cycle.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  sink accepts the byte when out_valid && out_ready.
- out_byte  output  8  current byte.
- out_last  output  1  high with the final byte of the dump (byte 3 of register NUM_REGS-1).

Behaviour:
- Reset (asynchronous, immediate) values:
  - state=IDLE, addr=0, byte_idx=0, word=0.
  - busy=0, done=0, out_valid=0, out_last=0, out_byte=0, rd_addr=0.
- rd_addr is always the internal addr register; it is never driven directly from start.
- IDLE: busy=0, out_valid=0.
  - start=1 → LOAD with addr=0.
  - start=0 → stay in IDLE.
- LOAD (1 cycle): busy=1, out_valid=0.
  - word <= rd_data for addr; byte_idx <= 0; → SEND.
- SEND: busy=1, out_valid=1, out_byte=word[8*byte_idx +: 8].
  - out_last = (addr==NUM_REGS-1) && (byte_idx==3).
  - On handshake with byte_idx<3: byte_idx++.
  - On handshake with byte_idx==3 and addr<NUM_REGS-1: addr++ → LOAD.
  - On handshake with byte_idx==3 and addr==NUM_REGS-1: → DONE.
  - Without handshake: out_valid, out_byte and out_last hold stable. out_valid never drops before acceptance.
- DONE (1 cycle): done=1, busy=1, out_valid=0; addr <= 0; → IDLE.
- Byte order: bit [7:0] first, then [15:8], [23:16], [31:24]. Registers go in ascending address order.
- Snapshot rule: a word is captured only in LOAD. Register-file writes during SEND do not affect bytes of the word being sent. They are visible if they land before that register's LOAD.
- Address 0 is read like any other address; the file returns 0 for it.
- Throughput with out_ready=1: 5 cycles per register. Total stream is 4*NUM_REGS bytes.
  - start at cycle 0 → LOAD at cycle 1 → first byte valid at cycle 2.
  - Last byte accepted at cycle 5*NUM_REGS (160 for the defaults); done at cycle 5*NUM_REGS+1 (161).
- start while busy is ignored and not queued. start held high through DONE begins a new dump on the cycle after DONE, when IDLE samples it.
- Reset mid-dump: outputs drop immediately, and the next dump restarts from address 0.
- Addr arithmetic never wraps past NUM_REGS-1; the DONE transition precedes any increment.

Test Plan:
- Reset then idle 10 cycles: busy=0, out_valid=0, done=0, rd_addr=0 throughout.
- Register model x_i = 0x11111111*i for i≥1, x0=0, out_ready=1, pulse start:
  - 128 bytes arrive: 00×4, then 11×4, then 22×4, and so on.
  - out_last is high only on byte 128.
  - done pulses at cycle 161 after start.
- Same model with out_ready toggling pseudo-randomly (~50%): identical byte sequence; out_byte and out_valid stable while out_ready=0; done follows the final handshake by exactly 1 cycle.
- Hold out_ready=0 while sending x5 byte 1, and write x5=0xDEADBEEF: the remaining x5 bytes still come from 0x55555555; x6 reads the model's current value.
- Assert rst_n=0 mid-dump at x10 byte 2: out_valid and busy fall in the same cycle. Then restart: the stream begins again at x0 byte 0.
- Pulse start again at x3 while busy: no effect, and a single 128-byte stream results. start held high continuously: back-to-back dumps, each exactly 128 bytes, separated by DONE and IDLE.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Debug register-file dumper: snapshots each register in address order and
// streams it out as little-endian bytes over a valid/ready byte interface.
module reg_dump_reader #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last
);

    localparam int unsigned LAST_ADDR = NUM_REGS - 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_idx;
    logic [DATA_W-1:0] word;

    logic       at_last_addr_c;
    logic       handshake_c;
    logic [1:0] next_idx_c;

    assign at_last_addr_c = (addr == ADDR_W'(LAST_ADDR));
    assign handshake_c    = out_valid && out_ready;
    assign next_idx_c     = byte_idx + 2'd1;
    assign rd_addr        = addr;

    // Single FSM; every output is a flop so the byte port stays glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            byte_idx  <= '0;
            word      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_byte  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (start) begin
                        addr  <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Snapshot point: later register-file writes cannot leak into this word.
                    word      <= rd_data;
                    byte_idx  <= 2'd0;
                    out_byte  <= rd_data[7:0];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    state     <= SEND;
                end
                SEND: begin
                    if (handshake_c) begin
                        if (byte_idx != 2'd3) begin
                            byte_idx <= next_idx_c;
                            out_byte <= 8'(word >> {next_idx_c, 3'b000});
                            out_last <= at_last_addr_c && (next_idx_c == 2'd3);
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (at_last_addr_c) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                addr  <= addr + ADDR_W'(1);
                                state <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    addr  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed self-checking bench for reg_dump_reader with a behavioural register file.
module tb_reg_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_last;

    logic [31:0] regs   [32];
    logic [31:0] golden [32];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int byte_no, done_rel, last_rel, last_cnt;

    reg_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last)
    );

    assign rd_data = regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_model();
        for (int i = 0; i < 32; i++) begin
            regs[i]   = 32'(32'h1111_1111 * i);
            golden[i] = regs[i];
        end
    endtask

    // mode 0: plain dump, 1: stall on x5 byte 1 and overwrite x5,
    // 2: reset at x10 byte 2, 3: extra start pulse at x3 byte 0.
    task automatic dump(input int mode, input bit rnd);
        int          t0;
        int          hold;
        bit          prev_stall;
        bit          fin;
        logic [7:0]  prev_byte;
        logic [31:0] w;
        byte_no = 0; done_rel = -1; last_rel = -1; last_cnt = 0;
        hold = 0; prev_stall = 0; fin = 0; prev_byte = '0;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 2000 && !fin; k++) begin
            if (k > 0) begin
                @(negedge clk);
                start = 1'b0;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_byte", 32'(out_byte), 32'(prev_byte));
            end
            if (done) begin
                done_rel = cyc - t0;
                fin = 1;
            end else if (mode == 2 && byte_no == 42 && out_valid) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                fin = 1;
            end else begin
                if (mode == 3 && byte_no == 12 && out_valid) start = 1'b1;
                if (mode == 1 && byte_no == 21 && out_valid && hold < 3) begin
                    out_ready = 1'b0;
                    hold++;
                    if (hold == 2) regs[5] = 32'hDEAD_BEEF;
                end else begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_valid && out_ready) begin
                    if (byte_no < 128) begin
                        w = golden[byte_no / 4];
                        chk($sformatf("byte%0d", byte_no), 32'(out_byte), 32'(w >> (8 * (byte_no % 4))) & 32'hFF);
                    end else begin
                        chk("extra_byte", 32'(byte_no), 32'd127);
                    end
                    if (out_last) begin
                        last_cnt++;
                        chk("last_pos", 32'(byte_no), 32'd127);
                    end
                    last_rel = cyc - t0;
                    byte_no++;
                end
                prev_stall = out_valid && !out_ready;
                prev_byte  = out_byte;
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_full(input string tag);
        chk({tag, "_bytes"}, 32'(byte_no), 32'd128);
        chk({tag, "_lastcnt"}, 32'(last_cnt), 32'd1);
        chk({tag, "_done_gap"}, 32'(done_rel - last_rel), 32'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dumps, bytes_in_dump, wait_idle;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        load_model();
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_byte", 32'(out_byte), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle without start.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_state", {busy, out_valid, done, rd_addr}, 32'd0);
        end

        // Full-speed dump with exact timing.
        dump(0, 0);
        chk("t_last_hs", 32'(last_rel), 32'd160);
        chk("t_done", 32'(done_rel), 32'd161);
        check_full("fast");

        // Random backpressure.
        dump(0, 1);
        check_full("rand");

        // Snapshot: x5 overwritten mid-send, x6 taken from the live model.
        regs[6]   = 32'hCAFE_F00D;
        golden[5] = 32'h5555_5555;
        golden[6] = 32'hCAFE_F00D;
        dump(1, 0);
        check_full("snap");
        load_model();

        // Reset mid-dump, then a clean restart from x0.
        dump(2, 0);
        chk("rst_at_byte", 32'(byte_no), 32'd42);
        chk("rst_addr_mid", 32'(rd_addr), 32'd0);
        dump(0, 0);
        chk("restart_t_done", 32'(done_rel), 32'd161);
        check_full("restart");

        // start while busy is ignored.
        dump(3, 0);
        chk("busystart_t_done", 32'(done_rel), 32'd161);
        check_full("busystart");

        // start held high: back-to-back dumps separated by DONE and IDLE.
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        dumps = 0; bytes_in_dump = 0; wait_idle = 0;
        for (int k = 0; k < 1000 && dumps < 2; k++) begin
            @(negedge clk);
            if (wait_idle) begin
                chk("b2b_idle_busy", 32'(busy), 32'd0);
                chk("b2b_idle_valid", 32'(out_valid), 32'd0);
                wait_idle = 0;
            end
            if (done) begin
                chk("b2b_bytes", 32'(bytes_in_dump), 32'd128);
                dumps++;
                bytes_in_dump = 0;
                wait_idle = 1;
                if (dumps == 2) start = 1'b0;
            end
            if (out_valid && out_ready) bytes_in_dump++;
        end
        chk("b2b_dumps", 32'(dumps), 32'd2);
        @(negedge clk);
        chk("b2b_end_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("b2b_stopped", {busy, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
